// File: rtl/leaf_out_arbiter_pkg.sv
// leaf_pkg: shared definitions for the leaf output arbiter.
//   - packet field offsets of the 49-bit leaf-to-BFT packet
//   - credit limits (receiver buffer depth)
//   - packet struct and output-register state enum
//   - saturating credit update helper
package leaf_pkg;

  localparam int unsigned PACKET_W  = 49;
  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned LEAF_W    = 4;
  localparam int unsigned PORT_W    = 4;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned SEL_BITS  = 3;  // width of cfg_sel / credit_sel / RR pointer

  localparam int unsigned VALID_BIT   = 48;
  localparam int unsigned LEAF_MSB    = 47;
  localparam int unsigned LEAF_LSB    = 44;
  localparam int unsigned PORT_MSB    = 43;
  localparam int unsigned PORT_LSB    = 40;
  localparam int unsigned ADDR_MSB    = 39;
  localparam int unsigned ADDR_LSB    = 33;
  localparam int unsigned PAD_BIT     = 32;
  localparam int unsigned PAYLOAD_MSB = 31;
  localparam int unsigned PAYLOAD_LSB = 0;

  localparam int unsigned CREDIT_MAX  = 1 << ADDR_W;
  localparam int unsigned CREDIT_BITS = ADDR_W + 1;

  typedef logic [CREDIT_BITS-1:0] credit_t;

  typedef struct packed {
    logic                 valid;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [ADDR_W-1:0]    addr;
    logic                 pad;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // A grant only happens with cur > 0, so the subtraction cannot underflow.
  function automatic credit_t credit_update(input credit_t cur, input logic take,
                                            input logic give, input int unsigned inc);
    int unsigned s;
    s = 32'(cur) + (give ? inc : 32'd0) - (take ? 32'd1 : 32'd0);
    return (s > CREDIT_MAX) ? CREDIT_BITS'(CREDIT_MAX) : CREDIT_BITS'(s);
  endfunction

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// leaf_out_arbiter_if: user-stream and BFT-egress signals of the leaf output arbiter.
//   din_leaf_user2interface  user payloads, port i at slice i
//   vld_user2interface       per-port valid
//   ack_interface2user       per-port accept pulse
//   bft_ready                BFT accepts the packet on dout
//   dout_leaf_interface2bft  packet to BFT
//   grant                    one-hot port granted this cycle
// master: environment side (drives data/valid/ready); slave: the arbiter.
interface leaf_out_arbiter_if
  import leaf_pkg::*;
#(
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned PAYLOAD_BITS  = PAYLOAD_W,
  parameter int unsigned PACKET_BITS   = PACKET_W
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic                                  bft_ready;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;
  logic [NUM_OUT_PORTS-1:0]              grant;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    output bft_ready,
    input  ack_interface2user,
    input  dout_leaf_interface2bft,
    input  grant
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    input  bft_ready,
    output ack_interface2user,
    output dout_leaf_interface2bft,
    output grant
  );
endinterface

// File: rtl/leaf_out_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req  request vector
//   ptr  highest-priority index this cycle
//   gnt  one-hot grant: first request at or after ptr, wrapping
module rr_arbiter
  import leaf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [SEL_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt
);

  logic [NUM_REQ-1:0] req_hi;
  logic               use_hi;
  logic               found;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  always_comb begin
    req_hi = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_hi[i] = req[i] && (i >= 32'(ptr));
    end
  end

  always_comb begin
    gnt    = '0;
    found  = 1'b0;
    use_hi = |req_hi;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && (use_hi ? req_hi[i] : req[i])) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin scheduler of NUM_OUT_PORTS user streams onto the
// single leaf-to-BFT packet channel, with per-port credit flow control and
// per-port destination/sequence-address stamping.
//   clk          clock
//   reset        asynchronous active-low reset
//   bus          user streams + BFT egress (slave modport)
//   cfg_we       destination config write strobe; cfg_sel selects the port
//   cfg_dest_leaf/cfg_dest_port  destination written for cfg_sel
//   credit_vld   freespace update strobe; credit_sel selects the port
module leaf_out_arbiter
  import leaf_pkg::*;
#(
  parameter int unsigned PACKET_BITS           = PACKET_W,
  parameter int unsigned PAYLOAD_BITS          = PAYLOAD_W,
  parameter int unsigned NUM_LEAF_BITS         = LEAF_W,
  parameter int unsigned NUM_PORT_BITS         = PORT_W,
  parameter int unsigned NUM_ADDR_BITS         = ADDR_W,
  parameter int unsigned NUM_OUT_PORTS         = 2,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  leaf_out_arbiter_if.slave        bus,
  input  logic                     cfg_we,
  input  logic [SEL_BITS-1:0]      cfg_sel,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic                     credit_vld,
  input  logic [SEL_BITS-1:0]      credit_sel
);

  credit_t                  credit    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_addr  [NUM_OUT_PORTS];
  logic                     cfg_valid [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] cfg_leaf  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] cfg_port  [NUM_OUT_PORTS];

  out_state_t          state;
  packet_t             pkt_q;
  packet_t             next_pkt;
  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] grant_idx;
  logic [SEL_BITS-1:0] next_ptr;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] req;
  logic [NUM_OUT_PORTS-1:0] gnt;
  logic                     out_free;
  logic                     any_grant;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.vld_user2interface[i] && (credit[i] != '0) && cfg_valid[i];
    end
  end

  assign out_free  = (state == OUT_EMPTY) || bus.bft_ready;
  assign req       = out_free ? eligible : '0;
  assign any_grant = |gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_OUT_PORTS)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Mux the granted port's payload and destination into the next packet.
  always_comb begin
    next_pkt       = '0;
    next_pkt.valid = 1'b1;
    grant_idx      = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt[i]) begin
        grant_idx        = SEL_BITS'(i);
        next_pkt.leaf    = cfg_leaf[i];
        next_pkt.port    = cfg_port[i];
        next_pkt.addr    = seq_addr[i];
        next_pkt.payload = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    if (grant_idx == SEL_BITS'(NUM_OUT_PORTS - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + SEL_BITS'(1);
    end
  end

  // Output register FSM: state mirrors dout[VALID_BIT].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= OUT_EMPTY;
      pkt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (any_grant) begin
            state  <= OUT_FULL;
            pkt_q  <= next_pkt;
            rr_ptr <= next_ptr;
          end
        end
        OUT_FULL: begin
          if (bus.bft_ready) begin
            if (any_grant) begin
              pkt_q  <= next_pkt;
              rr_ptr <= next_ptr;
            end else begin
              state       <= OUT_EMPTY;
              pkt_q.valid <= 1'b0;
            end
          end
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end

  // Per-port state. gnt is already gated by out_free, so a stalled register
  // leaves credits and addresses untouched. The packet above samples the old
  // cfg entry, so a same-cycle cfg write only affects later grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i]    <= CREDIT_BITS'(CREDIT_MAX);
        seq_addr[i]  <= '0;
        cfg_valid[i] <= 1'b0;
        cfg_leaf[i]  <= '0;
        cfg_port[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_update(credit[i], gnt[i],
                                   credit_vld && (credit_sel == SEL_BITS'(i)),
                                   FREESPACE_UPDATE_SIZE);
        if (gnt[i]) begin
          seq_addr[i] <= seq_addr[i] + NUM_ADDR_BITS'(1);
        end
        if (cfg_we && (cfg_sel == SEL_BITS'(i))) begin
          cfg_valid[i] <= 1'b1;
          cfg_leaf[i]  <= cfg_dest_leaf;
          cfg_port[i]  <= cfg_dest_port;
        end
      end
    end
  end

  assign bus.dout_leaf_interface2bft = PACKET_BITS'(pkt_q);
  assign bus.ack_interface2user      = gnt;
  assign bus.grant                   = gnt;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Testbench for leaf_out_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a queue-free behavioural model of the arbiter rules.
module tb_leaf_out_arbiter;
  import leaf_pkg::*;

  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_sel = '0;
  logic [3:0]  cfg_dest_leaf = '0;
  logic [3:0]  cfg_dest_port = '0;
  logic        credit_vld = 1'b0;
  logic [2:0]  credit_sel = '0;
  logic [63:0] din = '0;
  logic [1:0]  vld = '0;
  logic        bft_ready = 1'b0;
  logic [1:0]  ack;
  logic [1:0]  grant;
  logic [48:0] dout;

  leaf_out_arbiter_if #(.NUM_OUT_PORTS(NP), .PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

  assign bus.din_leaf_user2interface = din;
  assign bus.vld_user2interface      = vld;
  assign bus.bft_ready               = bft_ready;
  assign ack   = bus.ack_interface2user;
  assign grant = bus.grant;
  assign dout  = bus.dout_leaf_interface2bft;

  leaf_out_arbiter #(.NUM_OUT_PORTS(NP), .FREESPACE_UPDATE_SIZE(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .cfg_we        (cfg_we),
    .cfg_sel       (cfg_sel),
    .cfg_dest_leaf (cfg_dest_leaf),
    .cfg_dest_port (cfg_dest_port),
    .credit_vld    (credit_vld),
    .credit_sel    (credit_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_credit [NP];
  int          m_addr   [NP];
  bit          m_cfgv   [NP];
  logic [3:0]  m_leaf   [NP];
  logic [3:0]  m_port   [NP];
  int          m_ptr;
  logic [48:0] m_dout;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_credit[i] = 128;
      m_addr[i]   = 0;
      m_cfgv[i]   = 1'b0;
      m_leaf[i]   = '0;
      m_port[i]   = '0;
    end
    m_ptr  = 0;
    m_dout = '0;
  endtask

  always @(negedge clk) begin : cmp
    int          g;
    int          p;
    int          cs;
    bit          free;
    logic [1:0]  exp_gnt;
    if (!reset) begin
      model_reset();
    end else begin
      free = !m_dout[48] || bft_ready;
      g = -1;
      if (free) begin
        for (int k = 0; k < NP; k++) begin
          p = (m_ptr + k) % NP;
          if (g < 0 && vld[p] && m_credit[p] > 0 && m_cfgv[p]) g = p;
        end
      end
      exp_gnt = (g >= 0) ? 2'(1 << g) : 2'b00;
      check("cyc_dout",  64'(dout),  64'(m_dout));
      check("cyc_ack",   64'(ack),   64'(exp_gnt));
      check("cyc_grant", 64'(grant), 64'(exp_gnt));
      if (g >= 0) begin
        m_dout = {1'b1, m_leaf[g], m_port[g], 7'(m_addr[g]), 1'b0, din[g*32 +: 32]};
        m_credit[g] = m_credit[g] - 1;
        m_addr[g]   = (m_addr[g] + 1) % 128;
        m_ptr       = (g + 1) % NP;
      end else if (free) begin
        m_dout[48] = 1'b0;
      end
      cs = int'(credit_sel);
      if (credit_vld && cs < NP) begin
        m_credit[cs] = (m_credit[cs] + 64 > 128) ? 128 : m_credit[cs] + 64;
      end
      cs = int'(cfg_sel);
      if (cfg_we && cs < NP) begin
        m_cfgv[cs] = 1'b1;
        m_leaf[cs] = cfg_dest_leaf;
        m_port[cs] = cfg_dest_port;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    vld        = '0;
    bft_ready  = 1'b0;
    cfg_we     = 1'b0;
    credit_vld = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [3:0] leaf, input logic [3:0] port);
    cfg_we        = 1'b1;
    cfg_sel       = sel;
    cfg_dest_leaf = leaf;
    cfg_dest_port = port;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    n_bad++;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acks;
    int guard;

    // 1: reset state, single packet
    do_reset();
    @(negedge clk);
    check("rst_dout",  64'(dout),  64'h0);
    check("rst_ack",   64'(ack),   64'h0);
    check("rst_grant", 64'(grant), 64'h0);
    cyc();
    cfg_write(3'd0, 4'h5, 4'h1);
    din[31:0] = 32'hDEADBEEF;
    vld       = 2'b01;
    bft_ready = 1'b1;
    @(negedge clk);
    check("t1_ack", 64'(ack), 64'h1);
    cyc();
    vld = 2'b00;
    @(negedge clk);
    check("t1_dout", 64'(dout), 64'h1_5100_DEAD_BEEF);
    check("t1_ack_once", 64'(ack), 64'h0);
    check("t1_addr_model", 64'(m_addr[0]), 64'd1);
    cyc();
    din[31:0] = 32'h12345678;
    vld       = 2'b01;
    @(negedge clk);
    check("t1_ack2", 64'(ack), 64'h1);
    cyc();
    vld = 2'b00;
    @(negedge clk);
    check("t1_dout2", 64'(dout), 64'h1_5102_1234_5678);
    cyc();

    // 2: both ports, alternating grants at full rate
    do_reset();
    cfg_write(3'd0, 4'h3, 4'h2);
    cfg_write(3'd1, 4'h7, 4'h9);
    bft_ready = 1'b1;
    vld       = 2'b11;
    for (int n = 0; n < 4; n++) begin
      din = {32'hB000_0000 + 32'(n), 32'hA000_0000 + 32'(n)};
      @(negedge clk);
      check("t2_grant", 64'(grant), (n % 2 == 0) ? 64'h1 : 64'h2);
      if (n > 0) check("t2_dout_valid", 64'(dout[VALID_BIT]), 64'h1);
      cyc();
    end
    vld = 2'b00;
    @(negedge clk);
    check("t2_last_valid", 64'(dout[VALID_BIT]), 64'h1);
    cyc();
    @(negedge clk);
    check("t2_drained", 64'(dout[VALID_BIT]), 64'h0);
    cyc();

    // 3: BFT back-pressure for 3 cycles
    bft_ready = 1'b0;
    vld       = 2'b01;
    din[31:0] = 32'hC0FFEE00;
    @(negedge clk);
    check("t3_first_ack", 64'(ack), 64'h1);
    cyc();
    din[31:0] = 32'hC0FFEE01;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t3_stall_dout", 64'(dout), 64'h1_3204_C0FF_EE00);
      check("t3_stall_ack", 64'(ack), 64'h0);
      cyc();
    end
    check("t3_credit_model", 64'(m_credit[0]), 64'd125);
    bft_ready = 1'b1;
    @(negedge clk);
    check("t3_resume_ack", 64'(ack), 64'h1);
    cyc();
    vld = 2'b00;
    @(negedge clk);
    check("t3_resume_dout", 64'(dout), 64'h1_3206_C0FF_EE01);
    cyc();

    // 4: credit exhaustion and return
    do_reset();
    cfg_write(3'd0, 4'h1, 4'h1);
    bft_ready = 1'b1;
    vld       = 2'b01;
    acks      = 0;
    for (int n = 0; n < 140; n++) begin
      din[31:0] = 32'(n);
      @(negedge clk);
      if (ack[0]) acks++;
      cyc();
    end
    check("t4_acks", 64'(acks), 64'd128);
    check("t4_credit_model", 64'(m_credit[0]), 64'd0);
    check("t4_addr_model", 64'(m_addr[0]), 64'd0);
    @(negedge clk);
    check("t4_blocked", 64'(ack), 64'h0);
    cyc();
    credit_vld = 1'b1;
    credit_sel = 3'd0;
    @(negedge clk);
    check("t4_ret_cycle", 64'(ack), 64'h0);
    cyc();
    credit_vld = 1'b0;
    @(negedge clk);
    check("t4_regrant", 64'(ack), 64'h1);
    cyc();
    vld = 2'b00;
    check("t4_credit_after", 64'(m_credit[0]), 64'd63);
    @(negedge clk);
    check("t4_addr_wrapped", 64'(dout[ADDR_MSB:ADDR_LSB]), 64'd0);
    cyc();

    // 5: unconfigured port is never granted until configured
    do_reset();
    cfg_write(3'd0, 4'h2, 4'h2);
    bft_ready   = 1'b1;
    din[63:32]  = 32'h51;
    vld         = 2'b10;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("t5_unconfigured", 64'(ack), 64'h0);
      cyc();
    end
    cfg_we        = 1'b1;
    cfg_sel       = 3'd1;
    cfg_dest_leaf = 4'h6;
    cfg_dest_port = 4'h4;
    @(negedge clk);
    check("t5_cfg_cycle", 64'(ack), 64'h0);
    cyc();
    cfg_we = 1'b0;
    @(negedge clk);
    check("t5_granted", 64'(ack), 64'h2);
    cyc();
    vld = 2'b00;
    @(negedge clk);
    check("t5_dout", 64'(dout), 64'h1_6400_0000_0051);
    cyc();

    // 6: asynchronous reset with a packet held and credit0 = 10
    do_reset();
    cfg_write(3'd0, 4'h9, 4'h3);
    bft_ready = 1'b1;
    vld       = 2'b01;
    acks      = 0;
    guard     = 0;
    while (acks < 118 && guard < 200) begin
      din[31:0] = 32'(acks);
      @(negedge clk);
      if (ack[0]) acks++;
      guard++;
      cyc();
    end
    check("t6_acks", 64'(acks), 64'd118);
    vld       = 2'b00;
    bft_ready = 1'b0;
    check("t6_credit_model", 64'(m_credit[0]), 64'd10);
    @(negedge clk);
    check("t6_held_valid", 64'(dout[VALID_BIT]), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_clear", 64'(dout), 64'h0);
    cyc();
    cyc();
    reset = 1'b1;
    cfg_write(3'd0, 4'h9, 4'h3);
    bft_ready = 1'b1;
    vld       = 2'b01;
    acks      = 0;
    for (int n = 0; n < 135; n++) begin
      din[31:0] = 32'(n);
      @(negedge clk);
      if (n == 1) check("t6_addr_reset", 64'(dout[ADDR_MSB:ADDR_LSB]), 64'd0);
      if (ack[0]) acks++;
      cyc();
    end
    vld = 2'b00;
    check("t6_credit_reset", 64'(acks), 64'd128);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Schedules NUM_OUT_PORTS user output streams (32-bit vld/ack) onto the single 49-bit leaf-to-BFT packet channel.
- Uses round-robin arbitration and per-port credit (freespace) flow control.
- Stamps each packet with a configured destination leaf/port and a per-port 7-bit sequence address.
- Sits between the user kernel outputs (e.g. Output_1_V_V of an HLS page) and the BFT egress of the leaf interface.

Parameters:
- PACKET_BITS, 49, packet width to BFT.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 4, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, sequence address width; receiver buffer depth = 2^NUM_ADDR_BITS.
- NUM_OUT_PORTS, 2, arbitrated user streams (1..8).
- FREESPACE_UPDATE_SIZE, 64, credits returned per freespace update.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user data; port i at slice i.
- vld_user2interface  in  NUM_OUT_PORTS  per-port data valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port one-cycle accept pulse.
- cfg_we  in  1  destination config write strobe.
- cfg_sel  in  3  port index being configured.
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_dest_port  in  NUM_PORT_BITS  destination port.
- credit_vld  in  1  freespace update strobe.
- credit_sel  in  3  port receiving the update.
- bft_ready  in  1  BFT accepts the packet currently on dout.
- dout_leaf_interface2bft  out  PACKET_BITS  packet: [48]=valid, [47:44]=leaf, [43:40]=port, [39:33]=addr, [32]=0, [31:0]=payload.
- grant  out  NUM_OUT_PORTS  one-hot port granted this cycle (debug).

Behaviour:
- Reset values:
  - dout = 0; ack = 0; grant = 0.
  - RR pointer = 0.
  - Every credit counter = 2^NUM_ADDR_BITS (128).
  - Every seq addr = 0.
  - Every cfg entry invalid, dest = 0.
- cfg_we writes dest leaf/port for port cfg_sel and marks the entry valid. A write with cfg_sel >= NUM_OUT_PORTS is ignored.
- Port i is eligible when: vld[i]=1, credit[i] > 0 and cfg_valid[i]=1.
- The output register is free when dout[48]=0, or when bft_ready=1 in this cycle.
- When the register is free and any port is eligible, grant the first eligible port at or after the RR pointer, wrapping modulo NUM_OUT_PORTS. In that same cycle:
  - ack[grant]=1.
  - Payload, dest and addr are registered into dout with dout[48]=1, so the packet is visible the next cycle (1-cycle latency).
  - credit[grant] decrements by 1.
  - addr[grant] increments, wrapping 127 -> 0.
  - RR pointer = grant+1 mod NUM_OUT_PORTS.
- Register free and no port eligible: dout[48] clears to 0 and the other fields hold. RR pointer holds.
- Register not free (bft_ready=0 while dout[48]=1): dout holds unchanged, ack=0, and no state changes.
- Sustained throughput is one packet per cycle while bft_ready=1.
- Credit return: credit_vld adds FREESPACE_UPDATE_SIZE to credit[credit_sel], saturating at 128. A return with credit_sel >= NUM_OUT_PORTS is ignored.
- Grant and credit return on the same port in the same cycle: net change is +FREESPACE_UPDATE_SIZE-1, then saturate.
- A cfg write to the granted port in the same cycle: the packet uses the old dest; the new dest applies from the next grant.
- Reset asserted mid-packet: the register clears immediately and asynchronously. The in-flight packet is lost, and credits/addrs return to their reset values.
- State machine (2 states):
  - OUT_EMPTY: dout[48]=0.
  - OUT_FULL: dout[48]=1.
  - EMPTY->FULL on grant. FULL->FULL on grant while bft_ready=1. FULL->EMPTY when bft_ready=1 and no port is eligible. FULL holds while bft_ready=0.

Decomposition:
- Shared package leaf_pkg holds:
  - packet field offsets (VALID_BIT=48, LEAF_MSB/LSB, PORT_MSB/LSB, ADDR_MSB/LSB, PAYLOAD_MSB/LSB);
  - CREDIT_MAX = 2^NUM_ADDR_BITS;
  - the packet struct typedef.
- One sub-module: rr_arbiter (combinational request vector + pointer -> one-hot grant).
- Credit, addr and cfg arrays stay in the top module.

Test Plan:
- Reset, then cfg port0 -> leaf 5 / port 1, then vld0=1 with data 0xDEADBEEF, bft_ready=1.
  - Next cycle dout = {1,4'h5,4'h1,7'd0,1'b0,32'hDEADBEEF}; ack0 pulses once; addr0 = 1.
- Both ports configured, vld both held high, bft_ready=1.
  - Grants alternate 0,1,0,1 on consecutive cycles; one packet per cycle.
- bft_ready=0 for 3 cycles with a packet pending.
  - dout is stable, no ack, credits unchanged; transfer resumes the cycle after bft_ready=1.
- Port0 sends 128 packets with no credit return.
  - The 129th is not granted (ack0 stays 0); addr wrapped to 0.
  - credit_vld on port0 -> a grant the next cycle; credit = 63 after it.
- Unconfigured port1 with vld1=1.
  - Never acked; cfg write -> granted on the following cycle.
- Assert reset while dout[48]=1 and credit0 = 10.
  - dout = 0 asynchronously; after release credit0 = 128 and addr0 = 0.
